// File: rtl/systolic_pkg.sv
// Shared types for the systolic array front end.
// Default geometry, feeder states and the feature vector type.
package systolic_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ROW   = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feeder_state_e;

    typedef logic [DEF_WIDTH-1:0] feat_vec_t [DEF_ROW];

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth (data, valid) register chain with synchronous clear.
// The tail register drives the output directly.
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_valid,
    output logic [WIDTH-1:0] dly_data,
    output logic             dly_valid
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= src_data;
            valid_q[0] <= src_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign dly_data  = data_q[DEPTH-1];
    assign dly_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/feature_skew_feeder.sv
// Skews column slices of feature data onto the systolic array lanes,
// flushes the diagonal after the last beat and flags frame completion.
module feature_skew_feeder
    import systolic_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  ROW   = DEF_ROW,
    localparam int LW    = $clog2(ROW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LW-1:0]    num_lanes,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] feat_in [ROW],
    output logic [WIDTH-1:0] feat_out [ROW],
    output logic [ROW-1:0]   lane_valid,
    output logic             conv_ctrl,
    output logic             frame_done,
    output logic             busy
);

    feeder_state_e state_q, state_d;
    logic [LW-1:0] nl_q, nl_d;
    logic [LW-1:0] nl_in, nl_eff;
    logic [LW-1:0] drain_q, drain_d;
    logic [15:0]   beat_q, beat_d;
    logic          conv_q, conv_d;
    logic          accept;

    always_comb begin
        nl_in = num_lanes;
        if (num_lanes == '0) begin
            nl_in = LW'(1);
        end else if (num_lanes > LW'(ROW)) begin
            nl_in = LW'(ROW);
        end
    end

    assign in_ready   = (state_q != DRAIN);
    assign accept     = in_valid && in_ready;
    assign nl_eff     = (state_q == IDLE) ? nl_in : nl_q;
    assign busy       = (state_q != IDLE);
    assign conv_ctrl  = conv_q;
    assign frame_done = (state_q == DRAIN) && (drain_q == '0);

    // Lane r gets r+1 stages; idle or inactive lanes are fed zeros.
    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic             lane_on;
        logic [WIDTH-1:0] src_data;

        assign lane_on  = accept && (LW'(r) < nl_eff);
        assign src_data = lane_on ? feat_in[r] : '0;

        skew_delay_line #(
            .WIDTH(WIDTH),
            .DEPTH(r + 1)
        ) u_dly (
            .clk      (clk),
            .clr      (rst),
            .src_data (src_data),
            .src_valid(lane_on),
            .dly_data (feat_out[r]),
            .dly_valid(lane_valid[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            nl_q    <= LW'(1);
            drain_q <= '0;
            beat_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nl_q    <= nl_d;
            drain_q <= drain_d;
            beat_q  <= beat_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nl_d    = nl_q;
        drain_d = drain_q;
        beat_d  = beat_q;
        conv_d  = conv_q;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (accept) begin
                    nl_d   = nl_in;
                    conv_d = 1'b1;
                    beat_d = 16'd1;
                    if (in_last) begin
                        state_d = DRAIN;
                        drain_d = nl_in - LW'(1);
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_d = beat_q + 16'd1;
                    if (in_last) begin
                        state_d = DRAIN;
                        drain_d = nl_q - LW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                    conv_d  = 1'b0;
                end else begin
                    drain_d = drain_q - LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_feature_skew_feeder.sv
// Randomised bench for feature_skew_feeder against a cycle-indexed
// history model: lane r at cycle c shows the beat accepted at edge c-r.
module tb_feature_skew_feeder;

    localparam int W  = 16;
    localparam int R  = 32;
    localparam int LW = $clog2(R + 1);
    localparam int HN = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] num_lanes = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [W-1:0]  feat_in [R];
    logic [W-1:0]  feat_out [R];
    logic [R-1:0]  lane_valid;
    logic          conv_ctrl, frame_done, busy;

    int checks = 0;
    int errors = 0;

    int cyc = -1;
    int rst_e = -1;
    int last_e = -1;
    int m_nl = 1;
    bit m_busy = 0;
    bit g_acc;
    bit           h_acc [HN];
    int           h_nl [HN];
    logic [W-1:0] h_data [HN][R];
    logic [W-1:0] x_data [R];
    logic [R-1:0] x_lv;
    bit x_done, x_busy;
    bit x_ready = 1'b1;

    feature_skew_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .num_lanes (num_lanes),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .feat_in   (feat_in),
        .feat_out  (feat_out),
        .lane_valid(lane_valid),
        .conv_ctrl (conv_ctrl),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int clampn(int n);
        return (n < 1) ? 1 : ((n > R) ? R : n);
    endfunction

    // Advance one edge, update the model, then settle expectations.
    task automatic step();
        int e;
        @(posedge clk);
        cyc++;
        if (cyc >= HN) begin
            $display("FAIL history_overflow: cyc %0d limit %0d", cyc, HN);
            $fatal(1);
        end
        g_acc = !rst && in_valid && x_ready;
        h_acc[cyc] = g_acc;
        h_nl[cyc] = 0;
        if (rst) begin
            rst_e = cyc;
            m_busy = 0;
            last_e = -1;
        end else begin
            if (m_busy && last_e >= 0 && cyc == last_e + m_nl)
                m_busy = 0;
            if (g_acc) begin
                if (!m_busy) begin
                    m_nl = clampn(int'(num_lanes));
                    m_busy = 1;
                    last_e = -1;
                end
                h_nl[cyc] = m_nl;
                for (int r = 0; r < R; r++) h_data[cyc][r] = feat_in[r];
                if (in_last) last_e = cyc;
            end
        end
        #1;
        for (int r = 0; r < R; r++) begin
            e = cyc - r;
            if (e > rst_e && h_acc[e] && r < h_nl[e]) begin
                x_data[r] = h_data[e][r];
                x_lv[r] = 1'b1;
            end else begin
                x_data[r] = '0;
                x_lv[r] = 1'b0;
            end
        end
        x_done  = (last_e >= 0) && (cyc == last_e + m_nl - 1);
        x_ready = !((last_e >= 0) && (cyc >= last_e) && (cyc < last_e + m_nl));
        x_busy  = m_busy;
    endtask

    task automatic rand_feat();
        for (int r = 0; r < R; r++) feat_in[r] = W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        for (int r = 0; r < R; r++) feat_in[r] = '0;
        step();
        step();
        rst = 1'b0;
        for (int r = 0; r < R; r++) begin
            checks++;
            if (feat_out[r] !== '0 || lane_valid[r] !== 1'b0) begin
                errors++;
                $display("FAIL reset_lane%0d: got %h/%b want 0/0",
                         r, feat_out[r], lane_valid[r]);
            end
        end
        checks++;
        if ({frame_done, busy, conv_ctrl, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: done/busy/conv/rdy got %b want 0001",
                     {frame_done, busy, conv_ctrl, in_ready});
        end
    endtask

    task automatic test_main();
        int lst, dn;
        dn = -1;
        num_lanes = LW'(25);
        in_valid = 1'b1;
        for (int k = 0; k < 784 + 30; k++) begin
            if (k < 784) begin
                in_last = (k == 783);
                for (int r = 0; r < R; r++)
                    feat_in[r] = (r < 25) ? W'(r * 1000 + k) : W'($urandom);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            step();
            if (k == 0) num_lanes = LW'($urandom);
            if (k == 783) lst = cyc;
            if (frame_done === 1'b1) dn = cyc;
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL main_lane%0d cyc %0d: got %h/%b want %h/%b",
                             r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL main_ctrl cyc %0d: done/busy/conv/rdy got %b want %b",
                         cyc, {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
        end
        checks++;
        if (dn - lst !== 24) begin
            errors++;
            $display("FAIL main_done_offset: got %0d want 24", dn - lst);
        end
    endtask

    task automatic test_single();
        int v_cnt, c_cnt, v_at, d_at;
        v_cnt = 0; c_cnt = 0; v_at = -1; d_at = -2;
        num_lanes = LW'(1);
        in_valid = 1'b1;
        in_last = 1'b1;
        rand_feat();
        for (int k = 0; k < 7; k++) begin
            step();
            in_valid = 1'b0;
            in_last = 1'b0;
            if (lane_valid[0] === 1'b1) begin v_cnt++; v_at = k; end
            if (conv_ctrl === 1'b1) c_cnt++;
            if (frame_done === 1'b1) d_at = k;
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL single_lane%0d cyc %0d: got %h/%b want %h/%b",
                             r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL single_ctrl cyc %0d: got %b want %b", cyc,
                         {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
        end
        checks++;
        if (v_cnt !== 1 || c_cnt !== 1 || d_at !== v_at || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_shape: valid %0d conv %0d done@%0d valid@%0d busy %b want 1 1 equal 0",
                     v_cnt, c_cnt, d_at, v_at, busy);
        end
    endtask

    task automatic test_bubble();
        int f, lst, dn, hole_ok;
        dn = -1; hole_ok = 0;
        num_lanes = LW'(4);
        for (int s = 0; s < 16; s++) begin
            in_valid = (s < 7) && (s != 2);
            in_last = (s == 6);
            rand_feat();
            step();
            if (s == 0) f = cyc;
            if (s == 6) lst = cyc;
            if (frame_done === 1'b1) dn = cyc;
            if (cyc - f - 2 >= 0 && cyc - f - 2 < 4)
                if (lane_valid[cyc-f-2] === 1'b0 && feat_out[cyc-f-2] === '0)
                    hole_ok++;
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL bubble_lane%0d cyc %0d: got %h/%b want %h/%b",
                             r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL bubble_ctrl cyc %0d: got %b want %b", cyc,
                         {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (hole_ok !== 4 || dn - lst !== 3) begin
            errors++;
            $display("FAIL bubble_shape: holes %0d offset %0d want 4 3", hole_ok, dn - lst);
        end
    endtask

    task automatic test_clamp(input int n_req, input int n_exp);
        int lst, dn, tail;
        dn = -1; tail = 0;
        num_lanes = LW'(n_req);
        for (int s = 0; s < 40; s++) begin
            in_valid = (s < 3);
            in_last = (s == 2);
            rand_feat();
            step();
            if (s == 2) lst = cyc;
            if (frame_done === 1'b1) dn = cyc;
            if (lane_valid[R-1] === 1'b1) tail++;
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL clamp%0d_lane%0d cyc %0d: got %h/%b want %h/%b",
                             n_req, r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL clamp%0d_ctrl cyc %0d: got %b want %b", n_req, cyc,
                         {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (dn - lst !== n_exp - 1 || tail !== ((n_exp == R) ? 3 : 0)) begin
            errors++;
            $display("FAIL clamp%0d_shape: offset %0d tail %0d want %0d %0d",
                     n_req, dn - lst, tail, n_exp - 1, (n_exp == R) ? 3 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        num_lanes = LW'(25);
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_feat();
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < R; r++) begin
            checks++;
            if (feat_out[r] !== '0 || lane_valid[r] !== 1'b0) begin
                errors++;
                $display("FAIL abort_lane%0d: got %h/%b want 0/0",
                         r, feat_out[r], lane_valid[r]);
            end
        end
        checks++;
        if ({frame_done, busy, conv_ctrl, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_ctrl: got %b want 0001",
                     {frame_done, busy, conv_ctrl, in_ready});
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame_done === 1'b1) dones++;
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready} || lane_valid !== x_lv) begin
                errors++;
                $display("FAIL abort_quiet cyc %0d: got %b/%h want %b/%h", cyc,
                         {frame_done, busy, conv_ctrl, in_ready}, lane_valid,
                         {x_done, x_busy, x_busy, x_ready}, x_lv);
            end
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_random();
        int len, nacc, dones, budget;
        len = $urandom_range(60, 20);
        nacc = 0; dones = 0; budget = 0;
        num_lanes = LW'($urandom_range(40, 0));
        while (budget < 500) begin
            budget++;
            in_valid = (nacc < len) && ($urandom_range(3, 0) != 0);
            in_last = (nacc == len - 1);
            rand_feat();
            step();
            num_lanes = LW'($urandom);
            if (g_acc) nacc++;
            if (frame_done === 1'b1) dones++;
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL rand_lane%0d cyc %0d: got %h/%b want %h/%b",
                             r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got %b want %b", cyc,
                         {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
            if (nacc == len && !x_busy) break;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (dones !== 1 || budget >= 500) begin
            errors++;
            $display("FAIL rand_frame: dones %0d cycles %0d want 1 within 500", dones, budget);
        end
    endtask

    task automatic test_back_to_back();
        int k, frm, len, rdy_lo, hi_cnt, first_hi, last_hi, dones;
        k = 0; frm = 0; len = 4;
        rdy_lo = 0; hi_cnt = 0; first_hi = -1; last_hi = -1; dones = 0;
        num_lanes = LW'(5);
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_last = in_valid && (k == len - 1);
            rand_feat();
            step();
            if (in_ready === 1'b0) rdy_lo++;
            if (frame_done === 1'b1) dones++;
            if (conv_ctrl === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
                last_hi = c;
            end
            if (g_acc) begin
                k++;
                if (k == len) begin
                    k = 0;
                    if (frm == 0) begin frm = 1; len = 3; end
                    else in_valid = 1'b0;
                end
            end
            for (int r = 0; r < R; r++) begin
                checks++;
                if (feat_out[r] !== x_data[r] || lane_valid[r] !== x_lv[r]) begin
                    errors++;
                    $display("FAIL b2b_lane%0d cyc %0d: got %h/%b want %h/%b",
                             r, cyc, feat_out[r], lane_valid[r], x_data[r], x_lv[r]);
                end
            end
            checks++;
            if ({frame_done, busy, conv_ctrl, in_ready} !==
                {x_done, x_busy, x_busy, x_ready}) begin
                errors++;
                $display("FAIL b2b_ctrl cyc %0d: got %b want %b", cyc,
                         {frame_done, busy, conv_ctrl, in_ready},
                         {x_done, x_busy, x_busy, x_ready});
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (rdy_lo !== 10 || dones !== 2 || (last_hi - first_hi + 1 - hi_cnt) !== 1) begin
            errors++;
            $display("FAIL b2b_shape: rdy_low %0d dones %0d conv_gap %0d want 10 2 1",
                     rdy_lo, dones, last_hi - first_hi + 1 - hi_cnt);
        end
    endtask

    initial begin
        for (int r = 0; r < R; r++) feat_in[r] = '0;
        test_reset();
        test_main();
        test_single();
        test_bubble();
        test_clamp(0, 1);
        test_clamp(40, 32);
        test_reset_mid();
        for (int i = 0; i < 3; i++) test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
